// File: rtl/oob_device_responder_pkg.sv
// oob_device_responder_pkg: shared SATA primitives, device OOB state encodings and timer helper
package oob_device_responder_pkg;
  localparam logic [31:0] PRIM_ALIGN = 32'h7B4A4ABC;
  localparam logic [31:0] PRIM_SYNC  = 32'hB5B5957C;
  localparam logic [31:0] DIALTONE   = 32'h4A4A4A4A;
  typedef enum logic [3:0] {
    OOB_DEV_IDLE              = 4'h0,
    OOB_DEV_WAIT_FOR_RESET    = 4'h1,
    OOB_DEV_WAIT_FOR_NO_RESET = 4'h2,
    OOB_DEV_SEND_INIT         = 4'h3,
    OOB_DEV_WAIT_FOR_WAKE     = 4'h4,
    OOB_DEV_WAIT_FOR_NO_WAKE  = 4'h5,
    OOB_DEV_SEND_WAKE         = 4'h6,
    OOB_DEV_SEND_ALIGN        = 4'h7,
    OOB_DEV_READY             = 4'h8
  } oob_dev_state_e;
  function automatic logic [31:0] sat_dec(input logic [31:0] v);
    return (v == '0) ? '0 : v - 32'd1;
  endfunction
endpackage

// File: rtl/oob_prim_detect.sv
// oob_prim_detect: flags a received word as primitive PRIM (any K flag set, comma-aligned, data match)
// Ports: rx_din_i/rx_isk_i/rx_byte_is_aligned_i from the transceiver, match_o high on a valid primitive.
// Instantiate with PRIM_ALIGN or PRIM_SYNC; the host controller reuses it the same way.
module oob_prim_detect
  import oob_device_responder_pkg::*;
#(
  parameter logic [31:0] PRIM = PRIM_ALIGN
) (
  input  logic [31:0] rx_din_i,
  input  logic [3:0]  rx_isk_i,
  input  logic        rx_byte_is_aligned_i,
  output logic        match_o
);
  assign match_o = (rx_isk_i != 4'h0) && rx_byte_is_aligned_i && (rx_din_i == PRIM);
endmodule

// File: rtl/oob_device_responder.sv
// oob_device_responder: device-side SATA OOB handshake (COMRESET->COMINIT, COMWAKE->COMWAKE, ALIGN lock, SYNC)
// Ports: platform_ready gates the FSM; tx_comm_init/tx_comm_wake request OOB bursts, ended by
// tx_oob_complete or a timeout; comm_*_detect are host OOB events; rx_* feed ALIGN detection;
// tx_dout/tx_isk/tx_set_elec_idle drive the transmitter; linkup and lax_state report progress.
module oob_device_responder
  import oob_device_responder_pkg::*;
#(
  parameter logic [31:0] INIT_TIMEOUT      = 32'h000000A2,
  parameter logic [31:0] WAKE_TIMEOUT      = 32'h0000009B,
  parameter logic [31:0] HOST_WAKE_TIMEOUT = 32'h000203AD,
  parameter logic [31:0] ALIGN_TIMEOUT     = 32'h000203AD,
  parameter int unsigned ALIGN_COUNT       = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        platform_ready,
  output logic        linkup,
  output logic        tx_comm_init,
  output logic        tx_comm_wake,
  input  logic        tx_oob_complete,
  input  logic        comm_reset_detect,
  input  logic        comm_wake_detect,
  input  logic [31:0] rx_din,
  input  logic [3:0]  rx_isk,
  input  logic        rx_byte_is_aligned,
  output logic [31:0] tx_dout,
  output logic        tx_isk,
  output logic        tx_set_elec_idle,
  output logic [3:0]  lax_state
);
  localparam logic [3:0] ALIGN_LAST = 4'(ALIGN_COUNT - 1);
  oob_dev_state_e state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic [3:0] align_cnt_q, align_cnt_d;
  logic host_align, timeout, active;
  oob_prim_detect #(.PRIM(PRIM_ALIGN)) u_align_detect (
    .rx_din_i             (rx_din),
    .rx_isk_i             (rx_isk),
    .rx_byte_is_aligned_i (rx_byte_is_aligned),
    .match_o              (host_align)
  );
  assign timeout   = (timer_q == '0);
  assign lax_state = state_q;
  assign active    = (state_d == OOB_DEV_SEND_ALIGN) || (state_d == OOB_DEV_READY);
  always_comb begin
    state_d     = state_q;
    timer_d     = sat_dec(timer_q);
    align_cnt_d = align_cnt_q;
    case (state_q)
      OOB_DEV_IDLE:
        if (platform_ready) state_d = OOB_DEV_WAIT_FOR_RESET;
      OOB_DEV_WAIT_FOR_RESET:
        if (comm_reset_detect) state_d = OOB_DEV_WAIT_FOR_NO_RESET;
      OOB_DEV_WAIT_FOR_NO_RESET:
        if (!comm_reset_detect) begin
          state_d = OOB_DEV_SEND_INIT;
          timer_d = INIT_TIMEOUT;
        end
      OOB_DEV_SEND_INIT:
        if (timeout || tx_oob_complete) begin
          state_d = OOB_DEV_WAIT_FOR_WAKE;
          timer_d = HOST_WAKE_TIMEOUT;
        end
      OOB_DEV_WAIT_FOR_WAKE:
        if (comm_wake_detect) state_d = OOB_DEV_WAIT_FOR_NO_WAKE;
        else if (timeout) begin
          state_d = OOB_DEV_SEND_INIT;
          timer_d = INIT_TIMEOUT;
        end
      OOB_DEV_WAIT_FOR_NO_WAKE:
        if (!comm_wake_detect) begin
          state_d = OOB_DEV_SEND_WAKE;
          timer_d = WAKE_TIMEOUT;
        end
      OOB_DEV_SEND_WAKE:
        if (timeout || tx_oob_complete) begin
          state_d     = OOB_DEV_SEND_ALIGN;
          timer_d     = ALIGN_TIMEOUT;
          align_cnt_d = '0;
        end
      OOB_DEV_SEND_ALIGN: begin
        align_cnt_d = host_align ? align_cnt_q + 4'd1 : '0;
        if (host_align && align_cnt_q == ALIGN_LAST) state_d = OOB_DEV_READY;
        else if (timeout) state_d = OOB_DEV_IDLE;
      end
      OOB_DEV_READY: ;
      default: state_d = OOB_DEV_IDLE;
    endcase
    if (state_q != OOB_DEV_IDLE && !platform_ready)
      state_d = OOB_DEV_IDLE;
    else if (comm_reset_detect && !(state_q inside {OOB_DEV_IDLE, OOB_DEV_WAIT_FOR_RESET, OOB_DEV_WAIT_FOR_NO_RESET}))
      state_d = OOB_DEV_WAIT_FOR_NO_RESET;
  end
  // Strobes are high only while the burst state persists, so they drop on the same edge the burst ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= OOB_DEV_IDLE;
      timer_q          <= '0;
      align_cnt_q      <= '0;
      linkup           <= 1'b0;
      tx_comm_init     <= 1'b0;
      tx_comm_wake     <= 1'b0;
      tx_dout          <= '0;
      tx_isk           <= 1'b0;
      tx_set_elec_idle <= 1'b1;
    end else begin
      state_q          <= state_d;
      timer_q          <= timer_d;
      align_cnt_q      <= align_cnt_d;
      linkup           <= state_d == OOB_DEV_READY;
      tx_comm_init     <= state_q == OOB_DEV_SEND_INIT && state_d == OOB_DEV_SEND_INIT;
      tx_comm_wake     <= state_q == OOB_DEV_SEND_WAKE && state_d == OOB_DEV_SEND_WAKE;
      tx_dout          <= state_d == OOB_DEV_READY ? PRIM_SYNC : state_d == OOB_DEV_SEND_ALIGN ? PRIM_ALIGN : '0;
      tx_isk           <= active;
      tx_set_elec_idle <= !active;
    end
  end
endmodule
